// File: rtl/mem_access_if.sv
// ----------------------------------------------------------------------------
// mem_access_if
// Data-bus bundle between the load/store stage (master) and the memory
// system (slave). Uses the req/gnt/rvalid protocol:
//   bus_req_o    master -> slave  request, held until bus_gnt_i
//   bus_we_o     master -> slave  1 = write
//   bus_addr_o   master -> slave  word-aligned byte address
//   bus_be_o     master -> slave  byte enables
//   bus_wdata_o  master -> slave  lane-replicated write data
//   bus_gnt_i    slave -> master  request accepted
//   bus_rvalid_i slave -> master  response (read data or write ack) valid
//   bus_rdata_i  slave -> master  read data
//   bus_err_i    slave -> master  response error, qualified by bus_rvalid_i
// Signal suffixes are written from the master's point of view.
// ----------------------------------------------------------------------------
interface mem_access_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );
endinterface

// File: rtl/mem_access.sv
// ----------------------------------------------------------------------------
// mem_access
// Load/store stage that sits directly after execute. Accepts one load or
// store per idle cycle, forms byte enables and lane-replicated write data,
// runs one req/gnt/rvalid transaction on the data bus and returns aligned,
// extended load data as a registered register-file write.
//
// Ports
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   lsu_ld_en_i/st_en_i   load / store request (store wins if both set)
//   lsu_size_i            00 byte, 01 half, 10 word, 11 illegal
//   lsu_unsigned_i        loads: 1 = zero-extend, 0 = sign-extend
//   lsu_addr_i            byte address
//   lsu_wdata_i           store data
//   lsu_rd_i              load destination register
//   lsu_ready_o           1 = idle, request can be accepted this cycle
//   bus                   data-bus master port (mem_access_if.master)
//   lsu_reg_wr_o/addr_o/data_o  one-cycle register write
//   lsu_misalign_o        one-cycle pulse: misaligned or illegal size
//   lsu_bus_err_o         one-cycle pulse: bus error or timeout
// ----------------------------------------------------------------------------
module mem_access #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         lsu_ld_en_i,
    input  logic         lsu_st_en_i,
    input  logic [1:0]   lsu_size_i,
    input  logic         lsu_unsigned_i,
    input  logic [31:0]  lsu_addr_i,
    input  logic [31:0]  lsu_wdata_i,
    input  logic [4:0]   lsu_rd_i,
    output logic         lsu_ready_o,
    mem_access_if.master bus,
    output logic         lsu_reg_wr_o,
    output logic [4:0]   lsu_reg_addr_o,
    output logic [31:0]  lsu_reg_data_o,
    output logic         lsu_misalign_o,
    output logic         lsu_bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    // Last timer value at which the transaction may still complete; the
    // transaction therefore spends at most TIMEOUT cycles in REQ+RSP.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        reqWe_q, reqWe_d;
    logic [31:0] busAddr_q, busAddr_d;
    logic [3:0]  busBe_q, busBe_d;
    logic [31:0] busWdata_q, busWdata_d;
    logic [1:0]  ldSize_q, ldSize_d;
    logic        ldUnsigned_q, ldUnsigned_d;
    logic [1:0]  ldOffset_q, ldOffset_d;
    logic [4:0]  ldRd_q, ldRd_d;
    logic [7:0]  timer_q, timer_d;
    logic        regWr_q, regWr_d;
    logic [4:0]  regAddr_q, regAddr_d;
    logic [31:0] regData_q, regData_d;
    logic        misalign_q, misalign_d;
    logic        busErr_q, busErr_d;

    logic        accept;
    logic        misaligned;
    logic [3:0]  beNew;
    logic [31:0] wdataNew;
    logic        finish;

    // Shift the addressed lane down to bit 0, then extend per size/sign.
    function automatic logic [31:0] alignLoad(input logic [31:0] rdata,
                                              input logic [1:0]  offset,
                                              input logic [1:0]  size,
                                              input logic        uns);
        logic [31:0] shifted;
        shifted = rdata >> {offset, 3'b000};
        case (size)
            2'b00:   alignLoad = uns ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   alignLoad = uns ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: alignLoad = shifted;
        endcase
    endfunction

    // Request decode: alignment check, byte enables and replicated data.
    always_comb begin
        accept     = lsu_ld_en_i | lsu_st_en_i;
        misaligned = (lsu_size_i == 2'b11)
                   | ((lsu_size_i == 2'b01) & lsu_addr_i[0])
                   | ((lsu_size_i == 2'b10) & (lsu_addr_i[1:0] != 2'b00));
        case (lsu_size_i)
            2'b00: begin
                beNew    = 4'b0001 << lsu_addr_i[1:0];
                wdataNew = {4{lsu_wdata_i[7:0]}};
            end
            2'b01: begin
                beNew    = 4'b0011 << lsu_addr_i[1:0];
                wdataNew = {2{lsu_wdata_i[15:0]}};
            end
            default: begin
                beNew    = 4'b1111;
                wdataNew = lsu_wdata_i;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            reqWe_q      <= 1'b0;
            busAddr_q    <= '0;
            busBe_q      <= '0;
            busWdata_q   <= '0;
            ldSize_q     <= '0;
            ldUnsigned_q <= 1'b0;
            ldOffset_q   <= '0;
            ldRd_q       <= '0;
            timer_q      <= '0;
            regWr_q      <= 1'b0;
            regAddr_q    <= '0;
            regData_q    <= '0;
            misalign_q   <= 1'b0;
            busErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            reqWe_q      <= reqWe_d;
            busAddr_q    <= busAddr_d;
            busBe_q      <= busBe_d;
            busWdata_q   <= busWdata_d;
            ldSize_q     <= ldSize_d;
            ldUnsigned_q <= ldUnsigned_d;
            ldOffset_q   <= ldOffset_d;
            ldRd_q       <= ldRd_d;
            timer_q      <= timer_d;
            regWr_q      <= regWr_d;
            regAddr_q    <= regAddr_d;
            regData_q    <= regData_d;
            misalign_q   <= misalign_d;
            busErr_q     <= busErr_d;
        end
    end

    // Next-state logic. A response arriving in the final timer cycle still
    // completes normally; the timeout only fires when nothing came back.
    always_comb begin
        state_d      = state_q;
        reqWe_d      = reqWe_q;
        busAddr_d    = busAddr_q;
        busBe_d      = busBe_q;
        busWdata_d   = busWdata_q;
        ldSize_d     = ldSize_q;
        ldUnsigned_d = ldUnsigned_q;
        ldOffset_d   = ldOffset_q;
        ldRd_d       = ldRd_q;
        timer_d      = timer_q;
        regWr_d      = 1'b0;
        regAddr_d    = '0;
        regData_d    = '0;
        misalign_d   = 1'b0;
        busErr_d     = 1'b0;
        finish       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    timer_d = '0;
                    if (misaligned) begin
                        misalign_d = 1'b1;
                    end else begin
                        state_d      = REQ;
                        reqWe_d      = lsu_st_en_i;
                        busAddr_d    = {lsu_addr_i[31:2], 2'b00};
                        busBe_d      = beNew;
                        busWdata_d   = wdataNew;
                        ldSize_d     = lsu_size_i;
                        ldUnsigned_d = lsu_unsigned_i;
                        ldOffset_d   = lsu_addr_i[1:0];
                        ldRd_d       = lsu_rd_i;
                    end
                end
            end
            REQ: begin
                timer_d = timer_q + 8'd1;
                if (bus.bus_gnt_i && bus.bus_rvalid_i) begin
                    finish = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = IDLE;
                    busErr_d = 1'b1;
                end else if (bus.bus_gnt_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                timer_d = timer_q + 8'd1;
                if (bus.bus_rvalid_i) begin
                    finish = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d  = IDLE;
                    busErr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d = IDLE;
            if (bus.bus_err_i) begin
                busErr_d = 1'b1;
            end else if (!reqWe_q && (ldRd_q != 5'd0)) begin
                regWr_d   = 1'b1;
                regAddr_d = ldRd_q;
                regData_d = alignLoad(bus.bus_rdata_i, ldOffset_q, ldSize_q, ldUnsigned_q);
            end
        end
    end

    // Outputs: request fields come straight from the latched copies so they
    // stay stable for the whole REQ phase.
    always_comb begin
        lsu_ready_o     = (state_q == IDLE);
        bus.bus_req_o   = (state_q == REQ);
        bus.bus_we_o    = reqWe_q;
        bus.bus_addr_o  = busAddr_q;
        bus.bus_be_o    = busBe_q;
        bus.bus_wdata_o = busWdata_q;
        lsu_reg_wr_o    = regWr_q;
        lsu_reg_addr_o  = regAddr_q;
        lsu_reg_data_o  = regData_q;
        lsu_misalign_o  = misalign_q;
        lsu_bus_err_o   = busErr_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// ----------------------------------------------------------------------------
// tb_mem_access
// Self-checking bench for mem_access: a vector table of single transactions
// with hand-computed expected results, a scoreboard of expected register
// write / pulse outputs, and hand-written sequences for stray rvalid,
// timeout and reset in the middle of a transaction.
// ----------------------------------------------------------------------------
module tb_mem_access;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_ld_en_i;
    logic        lsu_st_en_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic [4:0]  lsu_rd_i;
    logic        lsu_ready_o;
    logic        lsu_reg_wr_o;
    logic [4:0]  lsu_reg_addr_o;
    logic [31:0] lsu_reg_data_o;
    logic        lsu_misalign_o;
    logic        lsu_bus_err_o;

    mem_access_if bus();

    mem_access #(.TIMEOUT(255)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lsu_ld_en_i    (lsu_ld_en_i),
        .lsu_st_en_i    (lsu_st_en_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_unsigned_i (lsu_unsigned_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wdata_i    (lsu_wdata_i),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_ready_o    (lsu_ready_o),
        .bus            (bus),
        .lsu_reg_wr_o   (lsu_reg_wr_o),
        .lsu_reg_addr_o (lsu_reg_addr_o),
        .lsu_reg_data_o (lsu_reg_data_o),
        .lsu_misalign_o (lsu_misalign_o),
        .lsu_bus_err_o  (lsu_bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic        misalign;
        logic        err;
        logic [4:0]  addr;
        logic [31:0] data;
    } expect_t;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int          gntDelay;
        int          rvDelay;
        logic        expMisalign;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expWr;
        logic        expErr;
        logic [31:0] expData;
    } vec_t;

    expect_t sbQueue[$];
    int      testsRun    = 0;
    int      testsFailed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, required);
        end
    endtask

    // Scoreboard: every output pulse must match the oldest expected entry.
    expect_t got;
    always @(negedge clk_i) begin
        if (!rst_i && (lsu_reg_wr_o || lsu_misalign_o || lsu_bus_err_o)) begin
            if (sbQueue.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL sb_unexpected: got wr=%b mis=%b err=%b, expected no output",
                         lsu_reg_wr_o, lsu_misalign_o, lsu_bus_err_o);
            end else begin
                got = sbQueue.pop_front();
                checkOutput("sb_flags", {29'd0, lsu_reg_wr_o, lsu_misalign_o, lsu_bus_err_o},
                            {29'd0, got.wr, got.misalign, got.err});
                checkOutput("sb_reg_addr", {27'd0, lsu_reg_addr_o}, {27'd0, got.addr});
                checkOutput("sb_reg_data", lsu_reg_data_o, got.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic driveReq(input logic ld, input logic st, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd);
        lsu_ld_en_i    = ld;
        lsu_st_en_i    = st;
        lsu_size_i     = size;
        lsu_unsigned_i = uns;
        lsu_addr_i     = addr;
        lsu_wdata_i    = wdata;
        lsu_rd_i       = rd;
    endtask

    // Runs one transaction from a vector; entered and left at posedge+1.
    task automatic applyStimulus(input vec_t v);
        expect_t e;
        driveReq(v.ld, v.st, v.size, v.uns, v.addr, v.wdata, v.rd);
        if (v.expWr || v.expMisalign || v.expErr) begin
            e.wr       = v.expWr;
            e.misalign = v.expMisalign;
            e.err      = v.expErr;
            e.addr     = v.expWr ? v.rd : 5'd0;
            e.data     = v.expData;
            sbQueue.push_back(e);
        end
        tick();
        lsu_ld_en_i = 1'b0;
        lsu_st_en_i = 1'b0;
        if (v.expMisalign) begin
            checkFlag("misalign_no_req", bus.bus_req_o, 1'b0);
            checkFlag("misalign_ready", lsu_ready_o, 1'b1);
            checkFlag("misalign_pulse", lsu_misalign_o, 1'b1);
        end else begin
            checkFlag("req_high", bus.bus_req_o, 1'b1);
            checkFlag("req_not_ready", lsu_ready_o, 1'b0);
            checkFlag("req_we", bus.bus_we_o, v.st);
            checkOutput("req_addr", bus.bus_addr_o, {v.addr[31:2], 2'b00});
            checkOutput("req_be", {28'd0, bus.bus_be_o}, {28'd0, v.expBe});
            checkOutput("req_wdata", bus.bus_wdata_o, v.expWdata);
            repeat (v.gntDelay) begin
                tick();
                checkFlag("req_held", bus.bus_req_o, 1'b1);
                checkOutput("req_be_held", {28'd0, bus.bus_be_o}, {28'd0, v.expBe});
                checkOutput("req_wdata_held", bus.bus_wdata_o, v.expWdata);
            end
            bus.bus_gnt_i = 1'b1;
            if (v.rvDelay == 0) begin
                bus.bus_rvalid_i = 1'b1;
                bus.bus_rdata_i  = v.rdata;
                bus.bus_err_i    = v.err;
            end
            tick();
            bus.bus_gnt_i    = 1'b0;
            bus.bus_rvalid_i = 1'b0;
            if (v.rvDelay > 0) begin
                checkFlag("rsp_req_low", bus.bus_req_o, 1'b0);
                repeat (v.rvDelay - 1) tick();
                bus.bus_rvalid_i = 1'b1;
                bus.bus_rdata_i  = v.rdata;
                bus.bus_err_i    = v.err;
                tick();
                bus.bus_rvalid_i = 1'b0;
                bus.bus_err_i    = 1'b0;
            end
            checkFlag("done_ready", lsu_ready_o, 1'b1);
            checkFlag("done_reg_wr", lsu_reg_wr_o, v.expWr);
            checkFlag("done_bus_err", lsu_bus_err_o, v.expErr);
        end
        bus.bus_err_i = 1'b0;
        tick();
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
    endtask

    vec_t vecs[15];
    int   cnt;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fields: ld st size uns addr wdata rd rdata err gntDelay rvDelay
        //         expMisalign expBe expWdata expWr expErr expData
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 1'b0, 0, 0,
                     1'b0, 4'b1111, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd7, 32'h80FF0000, 1'b0, 0, 0,
                     1'b0, 4'b1000, 32'h0, 1'b1, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd8, 32'h80FF0000, 1'b0, 0, 0,
                     1'b0, 4'b1000, 32'h0, 1'b1, 1'b0, 32'h00000080};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd0, 32'h0, 1'b0, 3, 1,
                     1'b0, 4'b1100, 32'hABCDABCD, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd5, 32'h0, 1'b0, 0, 0,
                     1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 5'd6, 32'hCAFEF00D, 1'b1, 1, 2,
                     1'b0, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 5'd3, 32'h80011234, 1'b0, 0, 1,
                     1'b0, 4'b1100, 32'h0, 1'b1, 1'b0, 32'hFFFF8001};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h300, 32'h0, 5'd4, 32'h8001F234, 1'b0, 1, 0,
                     1'b0, 4'b0011, 32'h0, 1'b1, 1'b0, 32'h0000F234};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h405, 32'h000000A5, 5'd0, 32'h0, 1'b0, 0, 0,
                     1'b0, 4'b0010, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 5'd0, 32'h0000AB00, 1'b0, 0, 0,
                     1'b0, 4'b0010, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 5'd2, 32'h0, 1'b0, 0, 0,
                     1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h500, 32'h11223344, 5'd9, 32'hFFFFFFFF, 1'b0, 0, 0,
                     1'b0, 4'b1111, 32'h11223344, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 5'd1, 32'h0, 1'b0, 0, 0,
                     1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 5'd11, 32'h007F0000, 1'b0, 2, 0,
                     1'b0, 4'b0100, 32'h0, 1'b1, 1'b0, 32'h0000007F};
        vecs[14] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h201, 32'h5555AAAA, 5'd0, 32'h0, 1'b0, 0, 0,
                     1'b1, 4'b0000, 32'h0, 1'b0, 1'b0, 32'h0};

        rst_i            = 1'b1;
        driveReq(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.bus_gnt_i    = 1'b0;
        bus.bus_rvalid_i = 1'b0;
        bus.bus_rdata_i  = 32'h0;
        bus.bus_err_i    = 1'b0;
        tick();
        tick();
        checkFlag("rst_ready", lsu_ready_o, 1'b1);
        checkFlag("rst_req", bus.bus_req_o, 1'b0);
        checkOutput("rst_be", {28'd0, bus.bus_be_o}, 32'd0);
        checkFlag("rst_reg_wr", lsu_reg_wr_o, 1'b0);
        checkOutput("rst_reg_data", lsu_reg_data_o, 32'd0);
        checkFlag("rst_misalign", lsu_misalign_o, 1'b0);
        checkFlag("rst_bus_err", lsu_bus_err_o, 1'b0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
        end

        // rvalid during REQ without a grant must be ignored.
        driveReq(1'b1, 1'b0, 2'b10, 1'b0, 32'h800, 32'h0, 5'd10);
        sbQueue.push_back('{1'b1, 1'b0, 1'b0, 5'd10, 32'h00000042});
        tick();
        lsu_ld_en_i      = 1'b0;
        bus.bus_rvalid_i = 1'b1;
        bus.bus_rdata_i  = 32'h99999999;
        tick();
        bus.bus_rvalid_i = 1'b0;
        checkFlag("stray_rvalid_req", bus.bus_req_o, 1'b1);
        checkFlag("stray_rvalid_no_wr", lsu_reg_wr_o, 1'b0);
        bus.bus_gnt_i    = 1'b1;
        bus.bus_rvalid_i = 1'b1;
        bus.bus_rdata_i  = 32'h00000042;
        tick();
        bus.bus_gnt_i    = 1'b0;
        bus.bus_rvalid_i = 1'b0;
        checkFlag("stray_done_wr", lsu_reg_wr_o, 1'b1);
        tick();
        checkOutput("stray_drained", 32'(sbQueue.size()), 32'd0);

        // Timeout: never granted, error pulse after TIMEOUT cycles in REQ.
        driveReq(1'b1, 1'b0, 2'b10, 1'b0, 32'hB00, 32'h0, 5'd13);
        sbQueue.push_back('{1'b0, 1'b0, 1'b1, 5'd0, 32'h0});
        tick();
        lsu_ld_en_i = 1'b0;
        cnt = 0;
        while (cnt < 300 && !lsu_bus_err_o) begin
            tick();
            cnt++;
        end
        checkOutput("timeout_cycles", 32'(cnt), 32'd255);
        checkFlag("timeout_ready", lsu_ready_o, 1'b1);
        checkFlag("timeout_req_low", bus.bus_req_o, 1'b0);
        checkFlag("timeout_no_wr", lsu_reg_wr_o, 1'b0);
        tick();
        checkOutput("timeout_drained", 32'(sbQueue.size()), 32'd0);

        // Reset while the request is on the bus drops it immediately.
        driveReq(1'b1, 1'b0, 2'b10, 1'b0, 32'h900, 32'h0, 5'd11);
        tick();
        lsu_ld_en_i = 1'b0;
        checkFlag("rstreq_req_before", bus.bus_req_o, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        checkFlag("rstreq_req_dropped", bus.bus_req_o, 1'b0);
        checkFlag("rstreq_ready", lsu_ready_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // Reset while waiting for the response; the late rvalid is ignored.
        driveReq(1'b1, 1'b0, 2'b10, 1'b0, 32'hA00, 32'h0, 5'd12);
        tick();
        lsu_ld_en_i   = 1'b0;
        bus.bus_gnt_i = 1'b1;
        tick();
        bus.bus_gnt_i = 1'b0;
        checkFlag("rstrsp_not_ready", lsu_ready_o, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        checkFlag("rstrsp_ready", lsu_ready_o, 1'b1);
        checkFlag("rstrsp_req_low", bus.bus_req_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        bus.bus_rvalid_i = 1'b1;
        bus.bus_rdata_i  = 32'h12345678;
        tick();
        bus.bus_rvalid_i = 1'b0;
        checkFlag("rstrsp_late_no_wr", lsu_reg_wr_o, 1'b0);
        checkFlag("rstrsp_late_ready", lsu_ready_o, 1'b1);
        tick();
        checkOutput("final_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
